scrolling_waveform_display: RTL and testbench

- Multi-channel successor to the single-trace waveform renderer.
- Captures incoming samples into a per-channel column ring buffer and renders each channel as a continuous trace of programmable thickness in its own horizontal lane over an optional grid.
- Supports sweep and scroll modes.
- Sits between the signal-processing chain and the VGA timing/output stage; outputs 4:4:4 RGB with fixed 2-cycle latency.

---
 rtl/scrolling_waveform_display.sv | 163 ++++++++++++++++
 tb/tb_scrolling_waveform_display.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/scrolling_waveform_display.sv
// scrolling_waveform_display: multi-channel scrolling/sweeping waveform renderer.
// Captures one sample per channel into a per-channel column ring buffer and renders each
// channel as a continuous trace in its own horizontal lane over an optional grid.
// Ports:
//   clock, reset_n         pixel clock, asynchronous active-low reset
//   hcount, vcount         current pixel column/row from the VGA timing stage
//   at_display_area        high in the visible region
//   sample_valid/sample_in one-cycle strobe; channel c at sample_in[c*W +: W]
//   freeze                 drop incoming samples and hold the buffer
//   scroll_mode            1 = scroll, 0 = sweep; latched at frame start
//   fill_level             columns written since reset, saturating at H_ACTIVE
//   r_out/g_out/b_out      4:4:4 RGB, two clocks behind hcount/vcount
module scrolling_waveform_display #(
    parameter int                    CHANNELS     = 2,
    parameter int                    SAMPLE_WIDTH = 8,
    parameter int                    H_ACTIVE     = 1024,
    parameter int                    LANE_HEIGHT  = 256,
    parameter int                    THICKNESS    = 3,
    parameter logic [CHANNELS*12-1:0] COLORS      = {12'h0F0, 12'hF00},
    parameter int                    GRID_SPACING = 64,
    parameter logic [11:0]           GRID_COLOR   = 12'h222,
    parameter logic [11:0]           CURSOR_COLOR = 12'hFFF
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [10:0]                      hcount,
    input  logic [9:0]                       vcount,
    input  logic                             at_display_area,
    input  logic                             sample_valid,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0] sample_in,
    input  logic                             freeze,
    input  logic                             scroll_mode,
    output logic [10:0]                      fill_level,
    output logic [3:0]                       r_out,
    output logic [3:0]                       g_out,
    output logic [3:0]                       b_out
);
    localparam int                AW     = $clog2(H_ACTIVE);
    localparam int                GM     = (GRID_SPACING > 0) ? GRID_SPACING - 1 : 0;
    localparam logic signed [11:0] HALF_T = 12'(THICKNESS / 2);
    localparam logic signed [11:0] S_MAX  = 12'(2 ** SAMPLE_WIDTH - 1);

    logic [SAMPLE_WIDTH-1:0] mem [CHANNELS][H_ACTIVE];

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, frame_base_q, rd_addr;
    logic [10:0]    fill_q, fill_d;
    logic           mode_q, render_q, we, frame_start;
    logic [11:0]    sum, wrapped, col;

    logic [SAMPLE_WIDTH-1:0] rd_q [CHANNELS];
    logic [10:0]             hcount_s1_q;
    logic [9:0]              vcount_s1_q;
    logic                    de_s1_q, col_ok_s1_q, cursor_s1_q;
    logic signed [11:0]      prev_y_q [CHANNELS];

    logic signed [11:0] y [CHANNELS];
    logic signed [11:0] py [CHANNELS];
    logic signed [11:0] lo [CHANNELS];
    logic signed [11:0] hi [CHANNELS];
    logic signed [11:0] v;
    logic [CHANNELS-1:0] hit;
    logic               grid;
    logic [11:0]        pix, rgb_q;

    // ---------------- capture ----------------
    always_comb begin
        we          = sample_valid & ~freeze;
        frame_start = (hcount == 11'd0) && (vcount == 10'd0);
        wr_ptr_d    = (wr_ptr_q == AW'(H_ACTIVE - 1)) ? '0 : wr_ptr_q + 1'b1;
        fill_d      = (fill_q == 11'(H_ACTIVE)) ? fill_q : fill_q + 11'd1;
    end

    always_ff @(posedge clock) begin
        if (we)
            for (int c = 0; c < CHANNELS; c++)
                mem[c][wr_ptr_q] <= sample_in[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end

    // frame_base latches the pre-write pointer, so a coincident write lands in column 0
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            frame_base_q <= '0;
            mode_q       <= 1'b0;
            render_q     <= 1'b0;
        end else begin
            if (frame_start) begin
                mode_q       <= scroll_mode;
                frame_base_q <= (fill_q == 11'(H_ACTIVE)) ? wr_ptr_q : '0;
                render_q     <= 1'b1;
            end
            if (we) begin
                wr_ptr_q <= wr_ptr_d;
                fill_q   <= fill_d;
            end
        end
    end

    assign fill_level = fill_q;

    // ---------------- stage 0: column address ----------------
    // blanking columns may map past the buffer; they are clamped and never displayed
    always_comb begin
        sum     = {1'b0, hcount} + 12'(frame_base_q);
        wrapped = (sum >= 12'(H_ACTIVE)) ? sum - 12'(H_ACTIVE) : sum;
        col     = mode_q ? wrapped : {1'b0, hcount};
        rd_addr = (col < 12'(H_ACTIVE)) ? AW'(col) : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                rd_q[c]     <= '0;
                prev_y_q[c] <= '0;
            end
            hcount_s1_q <= '0;
            vcount_s1_q <= '0;
            de_s1_q     <= 1'b0;
            col_ok_s1_q <= 1'b0;
            cursor_s1_q <= 1'b0;
            rgb_q       <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                rd_q[c]     <= mem[c][rd_addr];
                prev_y_q[c] <= y[c];
            end
            hcount_s1_q <= hcount;
            vcount_s1_q <= vcount;
            de_s1_q     <= at_display_area;
            col_ok_s1_q <= hcount < fill_q;
            // no cursor before the first sample so an empty buffer shows only the grid
            cursor_s1_q <= !mode_q && (fill_q != 11'd0) && (hcount == 11'(wr_ptr_q));
            rgb_q       <= (de_s1_q && render_q) ? pix : '0;
        end
    end

    // ---------------- stage 1: trace hit test ----------------
    // each trace spans from the previous column's row to this column's row, widened by
    // THICKNESS/2 and intersected with its own lane
    always_comb begin
        v = $signed({2'b00, vcount_s1_q});
        for (int c = 0; c < CHANNELS; c++) begin
            y[c]   = 12'(c * LANE_HEIGHT) + S_MAX - 12'(rd_q[c]);
            py[c]  = (hcount_s1_q == 11'd0) ? y[c] : prev_y_q[c];
            lo[c]  = ((y[c] < py[c]) ? y[c] : py[c]) - HALF_T;
            hi[c]  = ((y[c] > py[c]) ? y[c] : py[c]) + HALF_T;
            hit[c] = col_ok_s1_q && (v >= lo[c]) && (v <= hi[c]) &&
                     (v >= $signed(12'(c * LANE_HEIGHT))) &&
                     (v <= $signed(12'(c * LANE_HEIGHT + LANE_HEIGHT - 1)));
        end
        grid = (GRID_SPACING > 0) &&
               (((hcount_s1_q & 11'(GM)) == 11'd0) || ((vcount_s1_q & 10'(GM)) == 10'd0));
        pix = grid ? GRID_COLOR : 12'h000;
        pix = cursor_s1_q ? CURSOR_COLOR : pix;
        for (int c = CHANNELS - 1; c >= 0; c--)
            pix = hit[c] ? COLORS[c*12 +: 12] : pix;
    end

    // ---------------- stage 2: output ----------------
    assign {r_out, g_out, b_out} = rgb_q;

endmodule

// File: tb/tb_scrolling_waveform_display.sv
// tb_scrolling_waveform_display: directed + randomized bench with a pixel-level reference model.
module tb_scrolling_waveform_display;
    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [10:0] hcount = 11'd1100;
    logic [9:0]  vcount = 10'd700;
    logic        at_display_area = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_in = '0;
    logic        freeze = 1'b0;
    logic        scroll_mode = 1'b0;
    logic [10:0] fill_level;
    logic [3:0]  r_out, g_out, b_out;
    logic [11:0] rgb;

    assign rgb = {r_out, g_out, b_out};

    always #5 clock = ~clock;

    scrolling_waveform_display dut (
        .clock(clock), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .at_display_area(at_display_area), .sample_valid(sample_valid),
        .sample_in(sample_in), .freeze(freeze), .scroll_mode(scroll_mode),
        .fill_level(fill_level), .r_out(r_out), .g_out(g_out), .b_out(b_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [7:0]  mem_m [2][1024];
    int          wr_m, fill_m, fb_m;
    bit          mode_m, rnd_m;
    logic [11:0] exp_d1;
    bit          chk_d1;
    int          h_d1;
    logic [11:0] seen [1024];

    function automatic int col_y(int c, int x);
        int a;
        a = mode_m ? (fb_m + x) % 1024 : x;
        return c * 256 + 255 - int'(mem_m[c][a]);
    endfunction

    function automatic logic [11:0] ref_pix(int x, int v);
        int yc, yp, lo, hi;
        if (x < fill_m)
            for (int c = 0; c < 2; c++) begin
                yc = col_y(c, x);
                yp = (x == 0) ? yc : col_y(c, x - 1);
                lo = ((yc < yp) ? yc : yp) - 1;
                hi = ((yc > yp) ? yc : yp) + 1;
                if (lo < c * 256) lo = c * 256;
                if (hi > c * 256 + 255) hi = c * 256 + 255;
                if (v >= lo && v <= hi) return (c == 0) ? 12'hF00 : 12'h0F0;
            end
        if (!mode_m && fill_m > 0 && x == wr_m) return 12'hFFF;
        if (x % 64 == 0 || v % 64 == 0) return 12'h222;
        return 12'h000;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int h, input int v, input bit de, input bit sv, input logic [15:0] s);
        logic [11:0] e;
        hcount = 11'(h);
        vcount = 10'(v);
        at_display_area = de;
        sample_valid = sv;
        sample_in = s;
        e = ref_pix(h, v);
        if (h == 0 && v == 0) begin
            mode_m = scroll_mode;
            fb_m = (fill_m == 1024) ? wr_m : 0;
            rnd_m = 1'b1;
        end
        if (sv && !freeze) begin
            mem_m[0][wr_m] = s[7:0];
            mem_m[1][wr_m] = s[15:8];
            wr_m = (wr_m + 1) % 1024;
            if (fill_m < 1024) fill_m++;
        end
        if (!de || !rnd_m) e = 12'h000;
        @(posedge clock);
        #1;
        if (chk_d1) begin
            n_cmp++;
            assert (rgb === exp_d1) else begin
                n_bad++;
                $error("FAIL pixel x=%0d: got %h expected %h", h_d1, rgb, exp_d1);
            end
            if (h_d1 < 1024) seen[h_d1] = rgb;
        end
        exp_d1 = e;
        chk_d1 = 1'b1;
        h_d1 = h;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        check("rst_rgb", int'(rgb), 0);
        check("rst_fill", int'(fill_level), 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        wr_m = 0; fill_m = 0; fb_m = 0; mode_m = 1'b0; rnd_m = 1'b0; chk_d1 = 1'b0;
    endtask

    task automatic scan_row(input int v);
        for (int x = 0; x < 1024; x++) tick(x, v, 1'b1, 1'b0, 16'h0);
        tick(1100, v, 1'b0, 1'b0, 16'h0);
        tick(1101, v, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic frame_start(input bit sv, input logic [15:0] s);
        tick(0, 0, 1'b1, sv, s);
        tick(1100, 0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic write_sample(input logic [15:0] s);
        tick(1100, 700, 1'b0, 1'b1, s);
    endtask

    initial begin
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 1024; a++) mem_m[c][a] = 8'h00;
        @(posedge clock);
        #1;

        // empty buffer: only grid
        do_reset();
        frame_start(1'b0, 16'h0);
        scan_row(0);
        check("empty_r0_c65", int'(seen[65]), 12'h222);
        scan_row(300);
        check("empty_r300_c64", int'(seen[64]), 12'h222);
        check("empty_r300_c65", int'(seen[65]), 0);
        scan_row(700);
        check("empty_fill", int'(fill_level), 0);

        // sweep with ten constant samples
        for (int i = 0; i < 10; i++) write_sample(16'h0080);
        check("sweep_fill", int'(fill_level), 10);
        frame_start(1'b0, 16'h0);
        scan_row(126);
        check("sweep_r126_c5", int'(seen[5]), 12'hF00);
        scan_row(127);
        check("sweep_r127_c10", int'(seen[10]), 12'hFFF);
        check("sweep_r127_c11", int'(seen[11]), 0);
        scan_row(129);
        check("sweep_r129_c5", int'(seen[5]), 0);
        scan_row(511);
        check("sweep_r511_c5", int'(seen[5]), 12'h0F0);
        scan_row(512);
        check("sweep_r512_c5", int'(seen[5]), 12'h222);

        // step 00 -> FF between columns 3 and 4
        do_reset();
        for (int i = 0; i < 4; i++) write_sample({8'($urandom), 8'h00});
        for (int i = 0; i < 4; i++) write_sample({8'($urandom), 8'hFF});
        frame_start(1'b0, 16'h0);
        scan_row(0);
        check("step_r0_c4", int'(seen[4]), 12'hF00);
        check("step_r0_c3", int'(seen[3]), 12'h222);
        scan_row(100);
        check("step_r100_c4", int'(seen[4]), 12'hF00);
        check("step_r100_c3", int'(seen[3]), 0);
        scan_row(253);
        check("step_r253_c3", int'(seen[3]), 0);
        scan_row(254);
        check("step_r254_c3", int'(seen[3]), 12'hF00);
        scan_row(256);

        // scroll with 1030 samples: wraps, frame_base = 6
        do_reset();
        scroll_mode = 1'b1;
        for (int i = 0; i < 1030; i++) write_sample({8'($urandom), 8'(i)});
        check("scroll_fill", int'(fill_level), 1024);
        frame_start(1'b0, 16'h0);
        scan_row(250);
        check("scroll_r250_c0", int'(seen[0]), 12'hF00);
        check("scroll_r250_c1023", int'(seen[1023]), 12'hF00);
        scan_row(252);
        check("scroll_r252_c0", int'(seen[0]), 12'h222);
        check("scroll_r252_c1023", int'(seen[1023]), 12'hF00);
        scan_row($urandom_range(0, 255));
        scan_row($urandom_range(256, 511));
        scan_row($urandom_range(512, 767));

        // freeze: strobes are discarded
        freeze = 1'b1;
        for (int i = 0; i < 20; i++) write_sample(16'($urandom));
        freeze = 1'b0;
        check("freeze_fill", int'(fill_level), 1024);
        frame_start(1'b0, 16'h0);
        scan_row(250);
        check("freeze_r250_c0", int'(seen[0]), 12'hF00);
        check("freeze_r250_c1023", int'(seen[1023]), 12'hF00);

        // write coincident with frame start at wr_ptr=100
        for (int i = 0; i < 94; i++) write_sample(16'($urandom));
        frame_start(1'b1, {8'($urandom), 8'h40});
        scan_row(191);
        check("coinc_r191_c0", int'(seen[0]), 12'hF00);
        scroll_mode = 1'b0;
        frame_start(1'b0, 16'h0);
        scan_row(300);
        scan_row(100);

        // asynchronous reset mid-line
        for (int x = 0; x < 41; x++) tick(x, 256, 1'b1, 1'b0, 16'h0);
        do_reset();
        scan_row(256);
        check("post_rst_r256_c5", int'(seen[5]), 0);
        frame_start(1'b0, 16'h0);
        scan_row(256);
        check("resume_r256_c5", int'(seen[5]), 12'h222);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
